axil_cmd_master: RTL and testbench
==================================

Name: axil_cmd_master

Overview:
- Single-outstanding AXI-Lite manager (initiator) that turns a simple valid/ready command stream into AXI-Lite read or write transactions.
- Returns a single response beat per command.
- Used by accelerator control logic to drive our AXI-Lite BRAM ports and CSR blocks from inside the fabric.
- It is the initiator end of the AXI-Lite slaves already in the design.

Parameters:
- ADDR_WIDTH, 9, byte address width of the AXI-Lite bus and cmd_addr.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- PROT, 3'b000, constant driven on awprot/arprot.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address, forwarded unmodified.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  STRB_WIDTH  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write for this response.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP, passed through.
- m_axil_awaddr  out  ADDR_WIDTH
- m_axil_awprot  out  3
- m_axil_awvalid  out  1
- m_axil_awready  in  1
- m_axil_wdata  out  DATA_WIDTH
- m_axil_wstrb  out  STRB_WIDTH
- m_axil_wvalid  out  1
- m_axil_wready  in  1
- m_axil_bresp  in  2
- m_axil_bvalid  in  1
- m_axil_bready  out  1
- m_axil_araddr  out  ADDR_WIDTH
- m_axil_arprot  out  3
- m_axil_arvalid  out  1
- m_axil_arready  in  1
- m_axil_rdata  in  DATA_WIDTH
- m_axil_rresp  in  2
- m_axil_rvalid  in  1
- m_axil_rready  out  1

Behaviour:
- **Reset.** Asynchronous reset forces state IDLE. All valid/ready outputs go to 0 immediately, except cmd_ready, which becomes 1 once reset is released. All address/data/resp registers clear to 0.
- **Reset mid-transaction.** The transaction is abandoned; no rsp is produced.
- **State machine:** IDLE, WR (AW/W phase), WRESP (B phase), RD (AR phase), RDATA (R phase), RSP (hold response).
- **cmd_ready** = (state == IDLE); it is a registered-state decode with no combinational path from cmd_valid.
- **IDLE → WR** on accepted write:
  - Register addr, wdata and wstrb.
  - Set awvalid = wvalid = 1 on the next cycle, giving 1-cycle command-to-bus latency.
- **IDLE → RD** on accepted read: register addr and set arvalid = 1 on the next cycle.
- **WR phase:**
  - awvalid drops in the cycle after an AW handshake; wvalid drops in the cycle after a W handshake.
  - AW and W handshakes are independent and may occur in either order or in the same cycle. Done flags aw_done and w_done track them.
  - Move to WRESP when both are done, including when both handshakes occur in the same cycle.
- **WRESP:**
  - bready = 1.
  - On bvalid: capture bresp, set rsp_write = 1 and rsp_data = 0, then go to RSP.
- **RD:** arvalid is held until arready, then go to RDATA.
- **RDATA:**
  - rready = 1.
  - On rvalid: capture rdata and rresp, set rsp_write = 0, then go to RSP.
- **RSP:**
  - rsp_valid = 1 with payload stable.
  - On rsp_ready, return to IDLE; cmd_ready asserts in the following cycle.
  - The minimum command-to-command period is therefore 4 cycles for reads and 4 for writes with zero-wait slaves.
- **AXI rules:**
  - A valid, once asserted, is never deasserted before its handshake.
  - Payload is held stable while valid.
  - Valid never depends combinationally on ready.
  - bready and rready are asserted only in WRESP and RDATA respectively.
  - bvalid or rvalid arriving outside those states is ignored, since it cannot occur with a compliant slave.
- **Response codes:** no timeout. The resp code is passed through unchanged; SLVERR/DECERR are not interpreted.
- **Address handling:** cmd_addr is passed through unchanged; the block performs no alignment checking.

Decomposition:
- Shared package holds:
  - AXI resp constants: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - State encoding localparams for the FSM.
  - The default PROT value.
- No sub-module: a single FSM plus payload registers is natural at this size.

Test Plan:
- Write to a zero-wait slave: cmd addr=0x010, wdata=0xDEADBEEF, wstrb=4'hF → awaddr=0x010 and wdata=0xDEADBEEF presented the cycle after acceptance; one B beat returns rsp_write=1, rsp_resp=0, rsp_data=0.
- Read back 0x010 → araddr=0x010; rsp_data=0xDEADBEEF, rsp_resp=0, rsp_write=0.
- Slave asserts wready 3 cycles before awready; wstrb=4'b0011 → wvalid drops after its handshake, awvalid is held stable until awready, bready asserts only after both, and exactly one rsp is produced.
- rsp_ready held low 5 cycles, then a read with rresp=2'b10 (SLVERR) → rsp_valid and payload stable for all 5 cycles, rsp_resp=2'b10, cmd_ready=0 throughout.
- Back-to-back 8 alternating write/read commands to addresses 0x000..0x01C → every readback matches; cmd_ready never asserts while a transaction is in flight.
- rst asserted while arvalid=1 → arvalid, rready and rsp_valid go to 0 asynchronously; after release cmd_ready=1 and no response is emitted.

Source files
------------

// File: rtl/axil_cmd_master_pkg.sv
// Shared definitions for the AXI-Lite command master: response codes,
// FSM state encoding and the default protection attribute.
package axil_cmd_master_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite initiator: one valid/ready command in, one AXI-Lite
// read or write transaction out, one response beat back.
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int         ADDR_WIDTH = 9,
  parameter int         DATA_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [2:0] PROT       = PROT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  state_e                state_r, state_s;
  logic [ADDR_WIDTH-1:0] awaddr_r, awaddr_s, araddr_r, araddr_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s, rsp_data_r, rsp_data_s;
  logic [STRB_WIDTH-1:0] wstrb_r, wstrb_s;
  logic                  awvalid_r, awvalid_s, wvalid_r, wvalid_s, arvalid_r, arvalid_s;
  logic                  bready_r, bready_s, rready_r, rready_s;
  logic                  aw_done_r, aw_done_s, w_done_r, w_done_s;
  logic                  rsp_valid_r, rsp_valid_s, rsp_write_r, rsp_write_s;
  logic [1:0]            rsp_resp_r, rsp_resp_s;

  // Next-state and next-register values; every register holds unless a transition updates it
  always_comb begin
    state_s     = state_r;
    awaddr_s    = awaddr_r;
    araddr_s    = araddr_r;
    wdata_s     = wdata_r;
    wstrb_s     = wstrb_r;
    awvalid_s   = awvalid_r;
    wvalid_s    = wvalid_r;
    arvalid_s   = arvalid_r;
    bready_s    = bready_r;
    rready_s    = rready_r;
    aw_done_s   = aw_done_r;
    w_done_s    = w_done_r;
    rsp_valid_s = rsp_valid_r;
    rsp_write_s = rsp_write_r;
    rsp_data_s  = rsp_data_r;
    rsp_resp_s  = rsp_resp_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_write) begin
          state_s   = ST_WR;
          awaddr_s  = cmd_addr;
          wdata_s   = cmd_wdata;
          wstrb_s   = cmd_wstrb;
          awvalid_s = 1'b1;
          wvalid_s  = 1'b1;
          aw_done_s = 1'b0;
          w_done_s  = 1'b0;
        end else if (cmd_valid) begin
          state_s   = ST_RD;
          araddr_s  = cmd_addr;
          arvalid_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR: begin
        // AW and W complete independently; a same-cycle pair finishes both at once
        aw_done_s = aw_done_r | (awvalid_r & m_axil_awready);
        w_done_s  = w_done_r | (wvalid_r & m_axil_wready);
        awvalid_s = awvalid_r & ~m_axil_awready;
        wvalid_s  = wvalid_r & ~m_axil_wready;
        if (aw_done_s && w_done_s) begin
          state_s  = ST_WRESP;
          bready_s = 1'b1;
        end else begin
          state_s = ST_WR;
        end
      end
      ST_WRESP: begin
        if (m_axil_bvalid) begin
          state_s     = ST_RSP;
          bready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_write_s = 1'b1;
          rsp_data_s  = {DATA_WIDTH{1'b0}};
          rsp_resp_s  = m_axil_bresp;
        end else begin
          state_s = ST_WRESP;
        end
      end
      ST_RD: begin
        if (m_axil_arready) begin
          state_s   = ST_RDATA;
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
        end else begin
          state_s = ST_RD;
        end
      end
      ST_RDATA: begin
        if (m_axil_rvalid) begin
          state_s     = ST_RSP;
          rready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_write_s = 1'b0;
          rsp_data_s  = m_axil_rdata;
          rsp_resp_s  = m_axil_rresp;
        end else begin
          state_s = ST_RDATA;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
        end else begin
          state_s = ST_RSP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        arvalid_s   = 1'b0;
        bready_s    = 1'b0;
        rready_s    = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // State and payload registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      awaddr_r    <= {ADDR_WIDTH{1'b0}};
      araddr_r    <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      wstrb_r     <= {STRB_WIDTH{1'b0}};
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      bready_r    <= 1'b0;
      rready_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_data_r  <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= 2'b00;
    end else begin
      state_r     <= state_s;
      awaddr_r    <= awaddr_s;
      araddr_r    <= araddr_s;
      wdata_r     <= wdata_s;
      wstrb_r     <= wstrb_s;
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      arvalid_r   <= arvalid_s;
      bready_r    <= bready_s;
      rready_r    <= rready_s;
      aw_done_r   <= aw_done_s;
      w_done_r    <= w_done_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_write_r <= rsp_write_s;
      rsp_data_r  <= rsp_data_s;
      rsp_resp_r  <= rsp_resp_s;
    end
  end

  // cmd_ready decodes the state register only, masked low while reset is held
  assign cmd_ready      = (state_r == ST_IDLE) && !rst;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_write      = rsp_write_r;
  assign rsp_data       = rsp_data_r;
  assign rsp_resp       = rsp_resp_r;
  assign m_axil_awaddr  = awaddr_r;
  assign m_axil_awprot  = PROT;
  assign m_axil_awvalid = awvalid_r;
  assign m_axil_wdata   = wdata_r;
  assign m_axil_wstrb   = wstrb_r;
  assign m_axil_wvalid  = wvalid_r;
  assign m_axil_bready  = bready_r;
  assign m_axil_araddr  = araddr_r;
  assign m_axil_arprot  = PROT;
  assign m_axil_arvalid = arvalid_r;
  assign m_axil_rready  = rready_r;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Scoreboard bench for axil_cmd_master against a behavioural AXI-Lite memory slave
// with per-channel ready latency.
module tb_axil_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [8:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [8:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axil_cmd_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] mem [0:127];
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic [1:0]  next_bresp = 2'b00, next_rresp = 2'b00;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // AXI-Lite memory slave with programmable ready latency per address channel
  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_got, w_got;
    logic [8:0] wa, ra, smp_aw, smp_ar;
    logic [31:0] wd, smp_wd;
    logic [3:0] ws, smp_ws;
    int aw_c, w_c, ar_c;
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    aw_got = 1'b0; w_got = 1'b0; aw_c = 0; w_c = 0; ar_c = 0;
    wa = 9'h0; ra = 9'h0; wd = 32'h0; ws = 4'h0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid && awready; w_hs = wvalid && wready; b_hs = bvalid && bready;
      ar_hs = arvalid && arready; r_hs = rvalid && rready;
      smp_aw = awaddr; smp_wd = wdata; smp_ws = wstrb; smp_ar = araddr;
      @(posedge clk); #1;
      if (rst) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; aw_c = 0; w_c = 0; ar_c = 0;
      end else begin
        if (aw_hs) begin
          aw_got = 1'b1; wa = smp_aw; aw_c = 0; awready = (aw_lat == 0); aw_hs_cnt++;
        end else if (awvalid && !awready) begin
          if (aw_c >= aw_lat) awready = 1'b1; else aw_c++;
        end else if (!awvalid) begin
          aw_c = 0; awready = (aw_lat == 0);
        end
        if (w_hs) begin
          w_got = 1'b1; wd = smp_wd; ws = smp_ws; w_c = 0; wready = (w_lat == 0); w_hs_cnt++;
        end else if (wvalid && !wready) begin
          if (w_c >= w_lat) wready = 1'b1; else w_c++;
        end else if (!wvalid) begin
          w_c = 0; wready = (w_lat == 0);
        end
        if (b_hs) begin
          bvalid = 1'b0; b_hs_cnt++;
        end
        if (aw_got && w_got && !bvalid) begin
          for (int k = 0; k < 4; k++)
            if (ws[k]) mem[wa[8:2]][8*k +: 8] = wd[8*k +: 8];
          bvalid = 1'b1; bresp = next_bresp; aw_got = 1'b0; w_got = 1'b0;
        end
        if (r_hs) rvalid = 1'b0;
        if (ar_hs) begin
          ra = smp_ar; ar_c = 0; arready = (ar_lat == 0);
          rvalid = 1'b1; rdata = mem[ra[8:2]]; rresp = next_rresp;
        end else if (arvalid && !arready) begin
          if (ar_c >= ar_lat) arready = 1'b1; else ar_c++;
        end else if (!arvalid) begin
          ar_c = 0; arready = (ar_lat == 0);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake and checks protocol rules
  initial begin
    rsp_t e;
    logic have_prev = 1'b0;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
    logic [9:0] p_aw, p_ar;
    logic [36:0] p_w;
    logic [35:0] p_rsp;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rsp_unexpected: got write=%0b data=%0h resp=%0h, expected none",
                     rsp_write, rsp_data, rsp_resp);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_write", {63'h0, rsp_write}, {63'h0, e.w});
            chk("rsp_data", {32'h0, rsp_data}, {32'h0, e.d});
            chk("rsp_resp", {62'h0, rsp_resp}, {62'h0, e.r});
          end
        end
        if (have_prev && p_awv && !p_awr) chk("aw_hold", {54'h0, awvalid, awaddr}, {54'h0, p_aw});
        if (have_prev && p_wv && !p_wr) chk("w_hold", {27'h0, wvalid, wstrb, wdata}, {27'h0, p_w});
        if (have_prev && p_arv && !p_arr) chk("ar_hold", {54'h0, arvalid, araddr}, {54'h0, p_ar});
        if (have_prev && p_rv && !p_rr)
          chk("rsp_hold", {28'h0, rsp_valid, rsp_write, rsp_resp, rsp_data}, {28'h0, p_rsp});
        if (awvalid || wvalid || arvalid || bready || rready || rsp_valid)
          chk("cmd_ready_busy", {63'h0, cmd_ready}, 64'h0);
        if (bready)
          chk("bready_order", {63'h0, (aw_hs_cnt > b_hs_cnt) && (w_hs_cnt > b_hs_cnt)}, 64'h1);
        p_awv = awvalid; p_awr = awready; p_aw = {1'b1, awaddr};
        p_wv = wvalid; p_wr = wready; p_w = {1'b1, wstrb, wdata};
        p_arv = arvalid; p_arr = arready; p_ar = {1'b1, araddr};
        p_rv = rsp_valid; p_rr = rsp_ready; p_rsp = {1'b1, rsp_write, rsp_resp, rsp_data};
        have_prev = 1'b1;
      end
    end
  end

  task automatic issue(input logic wr, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er,
                       input bit expect_rsp);
    rsp_t e;
    bit ok = 1'b0;
    e.w = wr; e.d = ed; e.r = er;
    if (expect_rsp) exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL cmd_accept_timeout: got no accept, expected accept of addr %0h", a);
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {63'h0, ok}, 64'h1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 9'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
    chk("rst_valids", {58'h0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 64'h0);
    chk("rst_regs", {23'h0, awaddr, rsp_data}, 64'h0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", {63'h0, cmd_ready}, 64'h1);
    @(posedge clk); #1;

    // zero-wait write, bus presentation one cycle after acceptance
    issue(1'b1, 9'h010, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 1'b1);
    chk("wr_aw_bus", {53'h0, awvalid, wvalid, awaddr, 1'b0}, {53'h0, 1'b1, 1'b1, 9'h010, 1'b0});
    chk("wr_w_bus", {28'h0, wstrb, wdata}, {28'h0, 4'hF, 32'hDEADBEEF});
    chk("wr_prot", {61'h0, awprot}, 64'h0);
    wait_idle("wr_drain");

    issue(1'b0, 9'h010, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 1'b1);
    chk("rd_ar_bus", {54'h0, arvalid, araddr}, {54'h0, 1'b1, 9'h010});
    chk("rd_prot", {61'h0, arprot}, 64'h0);
    wait_idle("rd_drain");

    // W accepted three cycles ahead of AW, partial strobes
    aw_lat = 3;
    @(posedge clk); #1;
    issue(1'b1, 9'h020, 32'h12345678, 4'b0011, 32'h0, 2'b00, 1'b1);
    chk("skew_c1", {61'h0, awvalid, wvalid, bready}, {61'h0, 3'b110});
    @(posedge clk); #1;
    chk("skew_c2", {61'h0, awvalid, wvalid, bready}, {61'h0, 3'b100});
    wait_idle("skew_drain");
    aw_lat = 0;
    @(posedge clk); #1;
    issue(1'b0, 9'h020, 32'h0, 4'h0, 32'h00005678, 2'b00, 1'b1);
    wait_idle("strb_drain");

    // response backpressure with SLVERR read
    rsp_ready = 1'b0; next_rresp = 2'b10;
    issue(1'b0, 9'h010, 32'h0, 4'h0, 32'hDEADBEEF, 2'b10, 1'b1);
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp", {27'h0, rsp_valid, cmd_ready, rsp_write, rsp_resp, rsp_data},
          {27'h0, 1'b1, 1'b0, 1'b0, 2'b10, 32'hDEADBEEF});
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; next_rresp = 2'b00;
    wait_idle("bp_drain");

    // back-to-back write/read pairs over 0x000..0x01C
    for (int i = 0; i < 8; i++) begin
      d = 32'hC0DE0000 + 32'(i) * 32'h1111;
      issue(1'b1, 9'(i * 4), d, 4'hF, 32'h0, 2'b00, 1'b1);
      issue(1'b0, 9'(i * 4), 32'h0, 4'h0, d, 2'b00, 1'b1);
    end
    wait_idle("b2b_drain");

    // reset while a read address is stalled on the bus
    ar_lat = 10;
    @(posedge clk); #1;
    issue(1'b0, 9'h008, 32'h0, 4'h0, 32'h0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_arvalid", {63'h0, arvalid}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_outs", {59'h0, arvalid, rready, rsp_valid, bready, cmd_ready}, 64'h0);
    ar_lat = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", {63'h0, cmd_ready}, 64'h1);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_no_rsp", {63'h0, rsp_valid}, 64'h0);
    issue(1'b0, 9'h004, 32'h0, 4'h0, 32'hC0DE1111, 2'b00, 1'b1);
    wait_idle("post_rst_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
